// File: rtl/imem_loader_pkg.sv
// Shared definitions for the instruction-memory loader.
//
// Contents:
//   DEFAULT_MAX_WORDS : default instruction-memory depth in 32-bit words
//   state_t           : loader FSM states, fixed 3-bit encodings
//   state_rx_ready()  : states in which the byte stream is accepted
//   state_busy()      : states that count as an active load session
//
// The optional trailing-checksum feature is selected by the macro
// IMEM_LOADER_CHECKSUM_EN in the top level. S_CSUM always exists here,
// but the top level never enters it when the macro is undefined.

package imem_loader_pkg;

    localparam int DEFAULT_MAX_WORDS = 1024;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_HDR0  = 3'd1,
        S_HDR1  = 3'd2,
        S_DATA  = 3'd3,
        S_WRITE = 3'd4,
        S_CSUM  = 3'd5,
        S_DONE  = 3'd6,
        S_ERR   = 3'd7
    } state_t;

    function automatic logic state_rx_ready(input state_t s);
        return (s == S_HDR0) || (s == S_HDR1) || (s == S_DATA) || (s == S_CSUM);
    endfunction

    function automatic logic state_busy(input state_t s);
        return (s == S_HDR0) || (s == S_HDR1) || (s == S_DATA) ||
               (s == S_WRITE) || (s == S_CSUM);
    endfunction

endpackage

// File: rtl/imem_loader_byte_assembler.sv
// byte_assembler: packs four accepted bytes into one little-endian word.
//
// Ports:
//   CLK       : clock, rising edge
//   RESETB    : synchronous active-low reset
//   clear     : synchronous clear at the start of a new load session
//   take      : a data byte is accepted this cycle
//   rx_byte   : the byte being accepted
//   word_done : high in the cycle the 4th byte of a word is accepted
//   word      : the completed word, valid while word_done is high
//
// Only the first three bytes are stored. The fourth byte is still on the
// input when word_done fires, so the completed word is formed by
// concatenating it above the stored bytes; the caller registers it.

module byte_assembler (
    input  logic        CLK,
    input  logic        RESETB,
    input  logic        clear,
    input  logic        take,
    input  logic [7:0]  rx_byte,
    output logic        word_done,
    output logic [31:0] word
);

    logic [1:0]  byte_cnt;
    logic [23:0] shift_reg;

    // Bytes enter at the top and shift down, so the first byte of a word
    // ends up in the lowest byte lane.
    always_ff @(posedge CLK) begin
        if (!RESETB || clear) begin
            byte_cnt  <= 2'd0;
            shift_reg <= 24'd0;
        end else if (take) begin
            byte_cnt  <= byte_cnt + 2'd1;
            shift_reg <= {rx_byte, shift_reg[23:8]};
        end
    end

    assign word_done = take && (byte_cnt == 2'd3);
    assign word      = {rx_byte, shift_reg};

endmodule

// File: rtl/imem_loader.sv
// imem_loader: loads a program into instruction memory from a byte stream.
//
// Stream format: 16-bit little-endian word count N, then N words of four
// little-endian bytes each. When IMEM_LOADER_CHECKSUM_EN is defined, one
// more byte follows: the modulo-256 sum of all data bytes.
//
// Parameters:
//   MAX_WORDS : instruction-memory depth in words (larger N is an error)
//   CNT_W     : width of the header word-count field
//
// Ports:
//   CLK               : clock, rising edge
//   RESETB            : synchronous active-low reset
//   START             : one-cycle pulse that begins a session (IDLE/DONE/ERR)
//   RX_VALID/RX_DATA  : incoming byte stream
//   RX_READY          : loader can take a byte this cycle
//   PROGB             : low for one cycle per word written
//   INPUT_INSTRUCTION : word being written while PROGB is low
//   INPUT_ADDRESS     : byte address of that word
//   CPU_RESETB        : releases the core only in IDLE and DONE
//   BUSY/DONE/ERROR   : session status
//
// Every output is a flop loaded from the next-state decode. As a result,
// outputs always match the current state with no input-to-output path.

module imem_loader
    import imem_loader_pkg::*;
#(
    parameter int MAX_WORDS = DEFAULT_MAX_WORDS,
    parameter int CNT_W     = 16
) (
    input  logic        CLK,
    input  logic        RESETB,
    input  logic        START,
    input  logic        RX_VALID,
    input  logic [7:0]  RX_DATA,
    output logic        RX_READY,
    output logic        PROGB,
    output logic [31:0] INPUT_INSTRUCTION,
    output logic [31:0] INPUT_ADDRESS,
    output logic        CPU_RESETB,
    output logic        BUSY,
    output logic        DONE,
    output logic        ERROR
);

    state_t             state;
    state_t             next_state;
    logic               start_session;
    logic               rx_accept;
    logic [7:0]         count_lo;
    logic [15:0]        hdr_value;
    logic [CNT_W-1:0]   word_count;
    logic [CNT_W-1:0]   word_index;
    logic               word_done;
    logic [31:0]        assembled_word;

    assign rx_accept = RX_VALID && RX_READY;
    assign hdr_value = {RX_DATA, count_lo};

    byte_assembler u_byte_assembler (
        .CLK       (CLK),
        .RESETB    (RESETB),
        .clear     (start_session),
        .take      (rx_accept && (state == S_DATA)),
        .rx_byte   (RX_DATA),
        .word_done (word_done),
        .word      (assembled_word)
    );

`ifdef IMEM_LOADER_CHECKSUM_EN
    logic [7:0] checksum;

    // Running modulo-256 sum of data bytes; header bytes are not included.
    always_ff @(posedge CLK) begin
        if (!RESETB || start_session) begin
            checksum <= 8'd0;
        end else if (rx_accept && (state == S_DATA)) begin
            checksum <= checksum + RX_DATA;
        end
    end
`endif

    // Next-state logic. START only starts a session from IDLE, DONE or ERR.
    // Inside a session it is ignored.
    always_comb begin
        next_state    = state;
        start_session = 1'b0;
        case (state)
            S_IDLE, S_DONE, S_ERR: begin
                if (START) begin
                    next_state    = S_HDR0;
                    start_session = 1'b1;
                end
            end
            S_HDR0: begin
                if (rx_accept) begin
                    next_state = S_HDR1;
                end
            end
            S_HDR1: begin
                if (rx_accept) begin
                    if (hdr_value == 16'd0) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
                        next_state = S_CSUM;
`else
                        next_state = S_DONE;
`endif
                    end else if ({16'd0, hdr_value} > 32'(MAX_WORDS)) begin
                        next_state = S_ERR;
                    end else begin
                        next_state = S_DATA;
                    end
                end
            end
            S_DATA: begin
                if (word_done) begin
                    next_state = S_WRITE;
                end
            end
            S_WRITE: begin
                if ((word_index + CNT_W'(1)) < word_count) begin
                    next_state = S_DATA;
                end else begin
`ifdef IMEM_LOADER_CHECKSUM_EN
                    next_state = S_CSUM;
`else
                    next_state = S_DONE;
`endif
                end
            end
            S_CSUM: begin
`ifdef IMEM_LOADER_CHECKSUM_EN
                if (rx_accept) begin
                    next_state = (RX_DATA == checksum) ? S_DONE : S_ERR;
                end
`else
                // Unreachable without the checksum feature.
                // Fall back to IDLE if the register is ever corrupted.
                next_state = S_IDLE;
`endif
            end
            default: next_state = S_IDLE;
        endcase
    end

    // State, header capture, word index and the registered outputs. The
    // status outputs come from next_state, so they line up with the state.
    always_ff @(posedge CLK) begin
        if (!RESETB) begin
            state             <= S_IDLE;
            count_lo          <= 8'd0;
            word_count        <= '0;
            word_index        <= '0;
            RX_READY          <= 1'b0;
            PROGB             <= 1'b1;
            CPU_RESETB        <= 1'b0;
            BUSY              <= 1'b0;
            DONE              <= 1'b0;
            ERROR             <= 1'b0;
            INPUT_INSTRUCTION <= 32'd0;
            INPUT_ADDRESS     <= 32'd0;
        end else begin
            state      <= next_state;
            RX_READY   <= state_rx_ready(next_state);
            PROGB      <= (next_state != S_WRITE);
            CPU_RESETB <= (next_state == S_IDLE) || (next_state == S_DONE);
            BUSY       <= state_busy(next_state);
            DONE       <= (next_state == S_DONE);
            ERROR      <= (next_state == S_ERR);

            if ((state == S_HDR0) && rx_accept) begin
                count_lo <= RX_DATA;
            end
            if ((state == S_HDR1) && rx_accept) begin
                word_count <= CNT_W'(hdr_value);
            end

            if (start_session) begin
                word_index <= '0;
            end else if (state == S_WRITE) begin
                word_index <= word_index + CNT_W'(1);
            end

            if ((state == S_DATA) && word_done) begin
                INPUT_INSTRUCTION <= assembled_word;
                INPUT_ADDRESS     <= 32'({word_index, 2'b00});
            end
        end
    end

endmodule
